register_bank: RTL and testbench
================================

# register_bank

Parametrised register file that generalises the single bus register into NUM_REGS general-purpose registers with two combinational read ports, one write port, write-through bypass, an optional hardwired-zero R0, and a per-register busy scoreboard for multi-cycle producers (MUL/DIV, memory loads). It sits between the datapath bus and the control unit, which uses the busy flags and outstanding-reservation count to stall.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 16, number of registers (2..64, need not be a power of two).
- ADDR_WIDTH, $clog2(NUM_REGS), register address width.
- ZERO_R0, 1, when 1, R0 reads 0, ignores writes, is never busy.
- INIT, {DATA_WIDTH{1'b0}}, value loaded into every register on reset.

Ports (one clock; reset is asynchronous and active-high, named clear):
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- rd_addr_a  in  ADDR_WIDTH  read port A address.
- rd_data_a  out  DATA_WIDTH  read port A data (combinational).
- rd_busy_a  out  1  register A has an outstanding reservation.
- rd_addr_b, rd_data_b, rd_busy_b  same as port A, for port B.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rsv_en  in  1  reserve strobe (marks a register as pending).
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- busy_vec  out  NUM_REGS  busy bit per register.
- rsv_count  out  ADDR_WIDTH+1  number of busy registers.

## Operation
- Write: on a rising edge with wr_en=1 and a valid address, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Reserve: on a rising edge with rsv_en=1 and a valid address, busy[rsv_addr] <= 1.
- Write and reserve to the same address in one cycle: data is written and busy ends at 1 (the new producer wins).
- Reserving a register that is already busy: no change, no count change.
- Write to a non-busy register: allowed; data updates, busy stays 0.
- Read: rd_data_x = reg[rd_addr_x], except when wr_en=1, wr_addr==rd_addr_x, and the address is writable; then rd_data_x = wr_data (bypass).
- rd_busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x). The reservation in the current cycle does not affect rd_busy until the next cycle.
- ZERO_R0=1, address 0: reads return 0, rd_busy=0, writes and reserves are ignored, no bypass.
- Out-of-range address (>= NUM_REGS): reads return 0 with busy 0; writes and reserves are ignored.
- rsv_count: registered counter, net +1 per 0->1 busy transition and -1 per 1->0 transition in the same edge. It always equals popcount(busy_vec); range 0..NUM_REGS, with no wrap.

## Timing
- Reset (clear=1, asynchronous): all registers = INIT (R0 = 0 when ZERO_R0), busy_vec = 0, rsv_count = 0. rd_data_x reflects INIT immediately; rd_busy_x = 0.
- Write latency: 0 cycles through the bypass, 1 cycle through the storage.
- Reserve/busy latency: busy_vec and rsv_count update 1 edge after rsv_en. A write clears busy at the same edge.
- A clear asserted mid-operation drops all reservations; a wr_en or rsv_en in the same cycle has no effect.
- Deassertion of clear is synchronous to clock; the first edge with clear=0 accepts wr_en and rsv_en.

## Structure
- Shared package regbank_pkg: default DATA_WIDTH/NUM_REGS constants, the ZERO_R0 enable constant, and the address-valid helper function (addr < NUM_REGS and not (ZERO_R0 and addr==0)).
- One sub-module, regbank_read_port, instantiated twice: address decode, bypass mux, busy masking.
- Storage array, busy vector and count logic live in register_bank.

## Test plan
- Reset: set INIT=32'h0000_00A5 and pulse clear mid-cycle → all reads = 0xA5 (R0 = 0), busy_vec=0, rsv_count=0, asynchronously.
- Write/bypass: wr_en, wr_addr=3, wr_data=0xDEADBEEF with rd_addr_a=3 → rd_data_a=0xDEADBEEF in the same cycle; next cycle, with wr_en=0, it still reads 0xDEADBEEF.
- Scoreboard: reserve R5 then R7 → rsv_count 1 then 2, rd_busy for R5=1. Write R5=0x1234 → rd_busy_a=0 in that cycle via the mask; after the edge, busy_vec[5]=0 and rsv_count=1.
- Simultaneous events: wr_en and rsv_en both at R9 → after the edge reg9 = wr_data, busy[9]=1. rsv_en at R2 with wr_en at R7 (R7 busy) → count unchanged.
- R0 and range: with NUM_REGS=12, write/reserve R0 and R13 → all reads 0, busy 0, count 0.
- Full scoreboard: reserve all 15 writable registers → rsv_count=15. Re-reserve R1 → stays 15. Assert clear → 0.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared defaults and the address-valid helper for register_bank
package regbank_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam bit DEFAULT_ZERO_R0 = 1'b1;
  function automatic logic addr_valid(input int unsigned addr, input int unsigned num_regs, input bit zero_r0);
    return addr < num_regs && !(zero_r0 && addr == 0);
  endfunction
endpackage

// File: rtl/regbank_read_port.sv
// regbank_read_port: one combinational read port (addr decode, write bypass, busy mask); ports addr/regs/busy_vec/wr_* in, data/busy out
module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit ZERO_R0 = DEFAULT_ZERO_R0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0]   busy_vec,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy
);
  logic valid, hit;
  always_comb begin
    valid = addr_valid(32'(addr), NUM_REGS, ZERO_R0);
    hit = valid && wr_en && wr_addr == addr;
    data = !valid ? '0 : hit ? wr_data : regs[addr];
    busy = valid && !hit && busy_vec[addr];
  end
endmodule

// File: rtl/register_bank.sv
// register_bank: NUM_REGS register file, 2 read/1 write ports, bypass, busy scoreboard; clock/clear in, rd_*/busy_vec/rsv_count out
module register_bank
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit ZERO_R0 = DEFAULT_ZERO_R0,
  parameter logic [DATA_WIDTH-1:0] INIT = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [ADDR_WIDTH:0]   rsv_count
);
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, busy_next;
  logic [ADDR_WIDTH:0] count_next;
  logic wr_ok, rsv_ok, inc, dec;
  assign busy_vec = busy;
  always_comb begin
    wr_ok = wr_en && addr_valid(32'(wr_addr), NUM_REGS, ZERO_R0);
    rsv_ok = rsv_en && addr_valid(32'(rsv_addr), NUM_REGS, ZERO_R0);
    inc = rsv_ok && !busy[rsv_addr];
    // a same-address reserve keeps the bit set, so the write's release does not count
    dec = wr_ok && busy[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
    count_next = rsv_count + CW'(inc) - CW'(dec);
    for (int i = 0; i < NUM_REGS; i++)
      busy_next[i] = (busy[i] && !(wr_ok && wr_addr == ADDR_WIDTH'(i))) || (rsv_ok && rsv_addr == ADDR_WIDTH'(i));
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (ZERO_R0 && i == 0) ? '0 : INIT;
      busy <= '0;
      rsv_count <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy <= busy_next;
      rsv_count <= count_next;
    end
  end
  regbank_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .ZERO_R0(ZERO_R0)) port_a (
    .addr(rd_addr_a), .regs(regs), .busy_vec(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .data(rd_data_a), .busy(rd_busy_a)
  );
  regbank_read_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .ZERO_R0(ZERO_R0)) port_b (
    .addr(rd_addr_b), .regs(regs), .busy_vec(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .data(rd_data_b), .busy(rd_busy_b)
  );
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed stimulus, bench-side model compared every cycle, plus literal checkpoints
module tb_register_bank;
  localparam logic [31:0] INIT = 32'h0000_00A5;
  logic clock = 0, clear = 0;
  logic [3:0] rd_addr_a = 0, rd_addr_b = 0, wr_addr = 0, rsv_addr = 0;
  logic [31:0] wr_data = 0, rd_data_a, rd_data_b;
  logic wr_en = 0, rsv_en = 0, rd_busy_a, rd_busy_b;
  logic [15:0] busy_vec;
  logic [4:0] rsv_count;
  logic [3:0] s_rd_a = 0, s_rd_b = 0, s_wr_addr = 0, s_rsv_addr = 0;
  logic [31:0] s_wr_data = 0, s_data_a, s_data_b;
  logic s_wr_en = 0, s_rsv_en = 0, s_busy_a, s_busy_b;
  logic [11:0] s_busy_vec;
  logic [4:0] s_count;
  int n_cmp = 0, n_bad = 0;
  bit started = 0;
  logic [31:0] m_reg [16];
  bit m_busy [16];

  always #5 clock = ~clock;

  register_bank #(.INIT(INIT)) dut (
    .clock(clock), .clear(clear),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec), .rsv_count(rsv_count)
  );

  register_bank #(.NUM_REGS(12), .INIT(32'h11)) dut12 (
    .clock(clock), .clear(clear),
    .rd_addr_a(s_rd_a), .rd_data_a(s_data_a), .rd_busy_a(s_busy_a),
    .rd_addr_b(s_rd_b), .rd_data_b(s_data_b), .rd_busy_b(s_busy_b),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .busy_vec(s_busy_vec), .rsv_count(s_count)
  );

  function automatic bit writable(input int a);
    return a != 0 && a < 16;
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    if (!writable(a)) return 0;
    return (wr_en && int'(wr_addr) == a) ? wr_data : m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    return writable(a) && m_busy[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [15:0] v = 0;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i] = INIT;
        m_busy[i] = 0;
      end
    end else begin
      if (wr_en && writable(int'(wr_addr))) begin
        m_reg[wr_addr] = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (rsv_en && writable(int'(rsv_addr))) m_busy[rsv_addr] = 1;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("model rd_data_a", 64'(rd_data_a), 64'(exp_data(int'(rd_addr_a))));
      chk("model rd_data_b", 64'(rd_data_b), 64'(exp_data(int'(rd_addr_b))));
      chk("model rd_busy_a", 64'(rd_busy_a), 64'(exp_busy(int'(rd_addr_a))));
      chk("model rd_busy_b", 64'(rd_busy_b), 64'(exp_busy(int'(rd_addr_b))));
      chk("model busy_vec", 64'(busy_vec), 64'(exp_vec()));
      chk("model rsv_count", 64'(rsv_count), 64'(exp_count()));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rd_addr_a = 4;
    #3 clear = 1;
    #1;
    chk("reset init read", 64'(rd_data_a), 64'h0A5);
    chk("reset r0 read", 64'(rd_data_b), 64'h0);
    chk("reset busy_vec", 64'(busy_vec), 64'h0);
    chk("reset rsv_count", 64'(rsv_count), 64'h0);
    chk("reset busy a", 64'(rd_busy_a), 64'h0);
    started = 1;
    cyc();
    clear = 0;
    wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF; rd_addr_a = 3;
    #2 chk("bypass same cycle", 64'(rd_data_a), 64'hDEADBEEF);
    cyc();
    wr_en = 0;
    #2 chk("stored after write", 64'(rd_data_a), 64'hDEADBEEF);
    cyc();
    rsv_en = 1; rsv_addr = 5; rd_addr_a = 5;
    #2 chk("busy not yet visible", 64'(rd_busy_a), 64'h0);
    cyc();
    rsv_addr = 7;
    #2 chk("count after r5", 64'(rsv_count), 64'h1);
    chk("r5 busy", 64'(rd_busy_a), 64'h1);
    cyc();
    rsv_en = 0;
    #2 chk("count after r7", 64'(rsv_count), 64'h2);
    chk("vec r5 r7", 64'(busy_vec), 64'h00A0);
    cyc();
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
    #2 chk("write masks busy", 64'(rd_busy_a), 64'h0);
    chk("write r5 bypass", 64'(rd_data_a), 64'h1234);
    cyc();
    wr_en = 0;
    #2 chk("vec after r5 write", 64'(busy_vec), 64'h0080);
    chk("count after r5 write", 64'(rsv_count), 64'h1);
    cyc();
    wr_en = 1; wr_addr = 9; wr_data = 32'hCAFEF00D; rsv_en = 1; rsv_addr = 9; rd_addr_b = 9;
    #2 chk("r9 bypass", 64'(rd_data_b), 64'hCAFEF00D);
    chk("r9 busy masked", 64'(rd_busy_b), 64'h0);
    cyc();
    wr_en = 0; rsv_en = 0;
    #2 chk("r9 stored", 64'(rd_data_b), 64'hCAFEF00D);
    chk("r9 busy after wr+rsv", 64'(rd_busy_b), 64'h1);
    chk("count r7 r9", 64'(rsv_count), 64'h2);
    cyc();
    rsv_en = 1; rsv_addr = 2; wr_en = 1; wr_addr = 7; wr_data = 32'h7777;
    cyc();
    rsv_en = 0; wr_en = 0;
    #2 chk("count rsv2 wr7", 64'(rsv_count), 64'h2);
    chk("vec r2 r9", 64'(busy_vec), 64'h0204);
    cyc();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rsv_en = 1; rsv_addr = 0; rd_addr_a = 0;
    s_wr_en = 1; s_wr_addr = 0; s_wr_data = 32'hFFFFFFFF; s_rsv_en = 1; s_rsv_addr = 0; s_rd_a = 0; s_rd_b = 13;
    #2 chk("r0 no bypass", 64'(rd_data_a), 64'h0);
    chk("r0 not busy", 64'(rd_busy_a), 64'h0);
    chk("n12 r0 no bypass", 64'(s_data_a), 64'h0);
    cyc();
    wr_en = 0; rsv_en = 0;
    s_wr_addr = 13; s_rsv_addr = 13;
    #2 chk("r0 still zero", 64'(rd_data_a), 64'h0);
    chk("count unchanged by r0", 64'(rsv_count), 64'h2);
    chk("n12 r13 no bypass", 64'(s_data_b), 64'h0);
    chk("n12 r13 busy", 64'(s_busy_b), 64'h0);
    cyc();
    s_wr_en = 0; s_rsv_en = 0; s_rd_a = 5;
    #2 chk("n12 busy_vec", 64'(s_busy_vec), 64'h0);
    chk("n12 count", 64'(s_count), 64'h0);
    chk("n12 r13 read", 64'(s_data_b), 64'h0);
    chk("n12 r5 init", 64'(s_data_a), 64'h11);
    for (int i = 1; i < 16; i++) begin
      cyc();
      rsv_en = 1; rsv_addr = 4'(i);
    end
    cyc();
    rsv_addr = 1;
    #2 chk("full count", 64'(rsv_count), 64'd15);
    cyc();
    rsv_en = 0;
    #2 chk("re-reserve count", 64'(rsv_count), 64'd15);
    chk("full vec", 64'(busy_vec), 64'hFFFE);
    cyc();
    wr_en = 1; wr_addr = 4; wr_data = 32'h1; rsv_en = 1; rsv_addr = 4; rd_addr_a = 3; rd_addr_b = 4;
    #2 clear = 1;
    #1 chk("async clear count", 64'(rsv_count), 64'h0);
    chk("async clear vec", 64'(busy_vec), 64'h0);
    chk("async clear data", 64'(rd_data_a), 64'h0A5);
    cyc();
    wr_en = 0; rsv_en = 0;
    cyc();
    clear = 0;
    #2 chk("clear ignored write", 64'(rd_data_b), 64'h0A5);
    chk("clear ignored rsv", 64'(rd_busy_b), 64'h0);
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
